gamma_loader: RTL and testbench

- Controller that sequences loading of the 768-entry gamma LUT inside the mixer's gamma corrector over the 22-bit gamma bus, and owns its enable bit.
- Accepts a byte stream from the host-side config path (R table, then G, then B) and issues one LUT write per accepted byte.
- Optionally confines writes to vertical blank so a table change never tears mid-frame.
- Sits in the clk_sys domain between the host command decoder and the video_mixer gamma_bus port.

---
 rtl/gamma_loader_if.sv | 23 ++
 rtl/gamma_loader.sv | 142 ++++++++++++++
 tb/tb_gamma_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gamma_loader_if.sv
// Host-side handshake between the config path and the gamma LUT loader:
// enable level, start/abort pulses, byte stream and status.
interface gamma_loader_if;
  logic       enable;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output enable, start, abort, in_valid, in_data,
    input  in_ready, busy, done, error
  );

  modport slave (
    input  enable, start, abort, in_valid, in_data,
    output in_ready, busy, done, error
  );
endinterface

// File: rtl/gamma_loader.sv
// Sequences loading of the mixer gamma LUT over the 22-bit gamma bus, one write
// per accepted host byte, optionally only during vertical blank.
module gamma_loader #(
  parameter int ENTRIES   = 768,
  parameter bit VBL_ONLY  = 1'b1,
  parameter bit HIDE_LOAD = 1'b1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          vblank,
  gamma_loader_if.slave lb,
  inout  wire [21:0]    gamma_bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
  localparam logic [9:0] LAST_ADDR = 10'(ENTRIES - 1);

  logic [1:0] state_r;
  logic [9:0] addr_r;
  logic       wr_r;
  logic [9:0] wr_addr_r;
  logic [7:0] wr_data_r;
  logic       busy_r;
  logic       done_r;
  logic       error_r;
  logic       gamma_en_r;
  logic       vbl_meta_r;
  logic       vbl_sync_r;
  logic       in_ready_s;
  logic       accept_s;
  logic       present_s;

  assign present_s = gamma_bus[21];

  // Two-flop synchronizer for the video-domain vblank
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vbl_meta_r <= 1'b0;
      vbl_sync_r <= 1'b0;
    end else begin
      vbl_meta_r <= vblank;
      vbl_sync_r <= vbl_meta_r;
    end
  end

  // Ready only while loading, and only inside vblank when writes are confined
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == ST_LOAD) begin
      if (VBL_ONLY) begin
        in_ready_s = vbl_sync_r;
      end else begin
        in_ready_s = 1'b1;
      end
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = in_ready_s & lb.in_valid;

  // Load sequencer: state, address counter, registered LUT write and status
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      addr_r    <= 10'd0;
      wr_r      <= 1'b0;
      wr_addr_r <= 10'd0;
      wr_data_r <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      wr_r   <= accept_s;
      // A byte accepted in the abort cycle is still written; the handshake completed
      if (accept_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= lb.in_data;
        addr_r    <= addr_r + 10'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (lb.start) begin
            addr_r <= 10'd0;
            if (present_s) begin
              error_r <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= ST_LOAD;
            end else begin
              error_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (lb.start) begin
            error_r <= 1'b1;
          end
          if (lb.abort) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (accept_s && (addr_r == LAST_ADDR)) begin
            state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (lb.start) begin
            error_r <= 1'b1;
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Corrector enable, hidden while a load is in progress
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      gamma_en_r <= 1'b0;
    end else begin
      gamma_en_r <= lb.enable & ~(HIDE_LOAD & busy_r);
    end
  end

  assign lb.in_ready = in_ready_s;
  assign lb.busy     = busy_r;
  assign lb.done     = done_r;
  assign lb.error    = error_r;

  // Bit 21 belongs to the corrector (presence flag) and is left undriven here
  assign gamma_bus[20:0] = {clk_sys, gamma_en_r, wr_r, wr_addr_r, wr_data_r};

endmodule

// File: tb/tb_gamma_loader.sv
// Directed bench for gamma_loader: free-running load, vblank-confined load,
// gamma_en hiding, abort, missing corrector and asynchronous reset.
module tb_gamma_loader;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic reset_n;
  logic vblank0, vblank1;
  logic present0, present1;
  wire [21:0] bus0, bus1;

  assign bus0[21] = present0;
  assign bus1[21] = present1;

  gamma_loader_if h0();
  gamma_loader_if h1();

  gamma_loader #(.ENTRIES(768), .VBL_ONLY(1'b0), .HIDE_LOAD(1'b1)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank0), .lb(h0), .gamma_bus(bus0));

  gamma_loader #(.ENTRIES(768), .VBL_ONLY(1'b1), .HIDE_LOAD(1'b1)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank1), .lb(h1), .gamma_bus(bus1));

  int checks = 0;
  int errors = 0;

  logic [9:0] log_addr0 [0:4095];
  logic [7:0] log_data0 [0:4095];
  logic [9:0] log_addr1 [0:4095];
  logic [7:0] log_data1 [0:4095];
  int wr_cnt0 = 0, done_cnt0 = 0, wr_cnt1 = 0, done_cnt1 = 0;

  // Write/done monitor, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (bus0[18] === 1'b1 && wr_cnt0 < 4096) begin
      log_addr0[wr_cnt0] <= bus0[17:8];
      log_data0[wr_cnt0] <= bus0[7:0];
      wr_cnt0 <= wr_cnt0 + 1;
    end
    if (h0.done === 1'b1) done_cnt0 <= done_cnt0 + 1;
    if (bus1[18] === 1'b1 && wr_cnt1 < 4096) begin
      log_addr1[wr_cnt1] <= bus1[17:8];
      log_data1[wr_cnt1] <= bus1[7:0];
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (h1.done === 1'b1) done_cnt1 <= done_cnt1 + 1;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (h0.busy !== 1'b0 || h0.done !== 1'b0 || h0.error !== 1'b0) begin errors++; $display("FAIL rst_status0: got busy=%b done=%b error=%b expected 0 0 0", h0.busy, h0.done, h0.error); end
    checks++; if (h0.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b expected 0", h0.in_ready); end
    checks++; if (bus0[19:0] !== 20'd0) begin errors++; $display("FAIL rst_bus0: got %h expected 00000", bus0[19:0]); end
    checks++; if (bus1[19:0] !== 20'd0 || h1.busy !== 1'b0 || h1.in_ready !== 1'b0) begin errors++; $display("FAIL rst_dut1: got bus=%h busy=%b ready=%b expected 00000 0 0", bus1[19:0], h1.busy, h1.in_ready); end
    h0.enable = 1'b1;
    h1.enable = 1'b1;
    reset_n = 1'b1;
    step();
    checks++; if (bus0[19] !== 1'b1) begin errors++; $display("FAIL rst_en_follow: got %b expected 1", bus0[19]); end
    checks++; if (bus0[18] !== 1'b0 || h0.in_ready !== 1'b0) begin errors++; $display("FAIL rst_idle: got wr=%b ready=%b expected 0 0", bus0[18], h0.in_ready); end
    step();
  endtask

  task automatic test_full_load();
    int base, dn;
    base = wr_cnt0;
    dn = done_cnt0;
    h0.start = 1'b1;
    step();
    h0.start = 1'b0;
    for (int i = 0; i < 768; i++) begin
      h0.in_valid = 1'b1;
      h0.in_data = 8'(i);
      if (i == 0) begin
        checks++; if (h0.busy !== 1'b1) begin errors++; $display("FAIL full_busy_rise: got %b expected 1", h0.busy); end
        checks++; if (bus0[19] !== 1'b1) begin errors++; $display("FAIL full_en_lag: got %b expected 1", bus0[19]); end
        checks++; if (h0.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready: got %b expected 1", h0.in_ready); end
      end
      if (i == 1) begin
        checks++; if (bus0[19] !== 1'b0) begin errors++; $display("FAIL full_en_hidden: got %b expected 0", bus0[19]); end
      end
      step();
    end
    h0.in_valid = 1'b0;
    checks++; if (h0.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop: got %b expected 0", h0.in_ready); end
    checks++; if (bus0[18:0] !== {1'b1, 10'd767, 8'd255}) begin errors++; $display("FAIL full_last_write: got %h expected %h", bus0[18:0], {1'b1, 10'd767, 8'd255}); end
    checks++; if (h0.done !== 1'b0) begin errors++; $display("FAIL full_done_early: got %b expected 0", h0.done); end
    step();
    checks++; if (h0.done !== 1'b1 || h0.busy !== 1'b0) begin errors++; $display("FAIL full_done: got done=%b busy=%b expected 1 0", h0.done, h0.busy); end
    checks++; if (bus0[19] !== 1'b0 || bus0[18] !== 1'b0) begin errors++; $display("FAIL full_done_bus: got en=%b wr=%b expected 0 0", bus0[19], bus0[18]); end
    step();
    checks++; if (h0.done !== 1'b0 || bus0[19] !== 1'b1) begin errors++; $display("FAIL full_after: got done=%b en=%b expected 0 1", h0.done, bus0[19]); end
    checks++; if (h0.error !== 1'b0) begin errors++; $display("FAIL full_error: got %b expected 0", h0.error); end
    checks++; if (wr_cnt0 - base !== 768) begin errors++; $display("FAIL full_wr_count: got %0d expected 768", wr_cnt0 - base); end
    checks++; if (done_cnt0 - dn !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt0 - dn); end
    for (int i = 0; i < 768; i++) begin
      checks++; if (log_addr0[base + i] !== 10'(i) || log_data0[base + i] !== 8'(i)) begin errors++; $display("FAIL full_entry: got addr=%0d data=%0d expected %0d %0d", log_addr0[base + i], log_data0[base + i], i, i % 256); end
    end
    h0.abort = 1'b1;
    step();
    h0.abort = 1'b0;
    step();
    checks++; if (h0.error !== 1'b0 || h0.busy !== 1'b0) begin errors++; $display("FAIL idle_abort: got error=%b busy=%b expected 0 0", h0.error, h0.busy); end
  endtask

  task automatic test_no_present();
    int base, dn;
    base = wr_cnt0;
    dn = done_cnt0;
    present0 = 1'b0;
    step();
    h0.start = 1'b1;
    step();
    h0.start = 1'b0;
    checks++; if (h0.error !== 1'b1 || h0.busy !== 1'b0) begin errors++; $display("FAIL nopres_status: got error=%b busy=%b expected 1 0", h0.error, h0.busy); end
    h0.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (h0.in_ready !== 1'b0) begin errors++; $display("FAIL nopres_ready: got %b expected 0", h0.in_ready); end
      step();
    end
    h0.in_valid = 1'b0;
    step();
    checks++; if (wr_cnt0 !== base || done_cnt0 !== dn) begin errors++; $display("FAIL nopres_writes: got wr=%0d done=%0d expected 0 0", wr_cnt0 - base, done_cnt0 - dn); end
    present0 = 1'b1;
    step();
  endtask

  task automatic test_abort();
    int base, dn, base2;
    base = wr_cnt0;
    dn = done_cnt0;
    h0.start = 1'b1;
    step();
    h0.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      h0.in_valid = 1'b1;
      h0.in_data = 8'(i);
      step();
    end
    h0.in_valid = 1'b0;
    repeat (2) step();
    h0.abort = 1'b1;
    step();
    h0.abort = 1'b0;
    checks++; if (h0.busy !== 1'b0 || h0.error !== 1'b1 || h0.in_ready !== 1'b0) begin errors++; $display("FAIL abort_status: got busy=%b error=%b ready=%b expected 0 1 0", h0.busy, h0.error, h0.in_ready); end
    repeat (3) step();
    checks++; if (done_cnt0 !== dn) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt0 - dn); end
    checks++; if (wr_cnt0 - base !== 300) begin errors++; $display("FAIL abort_wr_count: got %0d expected 300", wr_cnt0 - base); end
    checks++; if (log_addr0[wr_cnt0 - 1] !== 10'd299) begin errors++; $display("FAIL abort_last_addr: got %0d expected 299", log_addr0[wr_cnt0 - 1]); end
    // start and abort together in IDLE: start wins and clears the error
    base2 = wr_cnt0;
    h0.start = 1'b1;
    h0.abort = 1'b1;
    step();
    h0.start = 1'b0;
    h0.abort = 1'b0;
    checks++; if (h0.busy !== 1'b1 || h0.error !== 1'b0 || h0.in_ready !== 1'b1) begin errors++; $display("FAIL restart_status: got busy=%b error=%b ready=%b expected 1 0 1", h0.busy, h0.error, h0.in_ready); end
    for (int i = 0; i < 10; i++) begin
      h0.in_valid = 1'b1;
      h0.in_data = 8'(i + 16);
      h0.start = (i == 4) ? 1'b1 : 1'b0;
      step();
    end
    h0.in_valid = 1'b0;
    h0.start = 1'b0;
    checks++; if (h0.error !== 1'b1 || h0.busy !== 1'b1) begin errors++; $display("FAIL busy_start: got error=%b busy=%b expected 1 1", h0.error, h0.busy); end
    repeat (2) step();
    checks++; if (wr_cnt0 - base2 !== 10) begin errors++; $display("FAIL restart_count: got %0d expected 10", wr_cnt0 - base2); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (log_addr0[base2 + i] !== 10'(i) || log_data0[base2 + i] !== 8'(i + 16)) begin errors++; $display("FAIL restart_entry: got addr=%0d data=%0d expected %0d %0d", log_addr0[base2 + i], log_data0[base2 + i], i, i + 16); end
    end
    h0.abort = 1'b1;
    step();
    h0.abort = 1'b0;
    checks++; if (h0.busy !== 1'b0) begin errors++; $display("FAIL restart_abort: got busy=%b expected 0", h0.busy); end
    step();
  endtask

  task automatic test_vblank();
    int base, dn, sent, t, periods, last_period;
    logic vb_now, vb_d1, vb_d2, exp_ready, prev_acc;
    base = wr_cnt1;
    dn = done_cnt1;
    sent = 0;
    t = 0;
    periods = 0;
    last_period = -1;
    vb_d1 = 1'b0;
    vb_d2 = 1'b0;
    prev_acc = 1'b0;
    vblank1 = 1'b0;
    repeat (3) step();
    h1.start = 1'b1;
    step();
    h1.start = 1'b0;
    h1.in_valid = 1'b1;
    while (sent < 768 && t < 1400) begin
      vb_now = ((t % 150) < 100) ? 1'b1 : 1'b0;
      vblank1 = vb_now;
      h1.in_data = 8'(sent);
      exp_ready = vb_d2;
      checks++; if (h1.in_ready !== exp_ready) begin errors++; $display("FAIL vbl_ready t=%0d: got %b expected %b", t, h1.in_ready, exp_ready); end
      checks++; if (bus1[18] !== prev_acc) begin errors++; $display("FAIL vbl_wr t=%0d: got %b expected %b", t, bus1[18], prev_acc); end
      if (exp_ready && (t / 150) != last_period) begin
        periods++;
        last_period = t / 150;
      end
      step();
      vb_d2 = vb_d1;
      vb_d1 = vb_now;
      if (exp_ready) sent++;
      prev_acc = exp_ready;
      t++;
    end
    checks++; if (sent !== 768) begin errors++; $display("FAIL vbl_timeout: got %0d bytes expected 768", sent); end
    checks++; if (h1.in_ready !== 1'b0 || bus1[18:8] !== {1'b1, 10'd767}) begin errors++; $display("FAIL vbl_last: got ready=%b wr/addr=%h expected 0 %h", h1.in_ready, bus1[18:8], {1'b1, 10'd767}); end
    step();
    checks++; if (h1.done !== 1'b1 || h1.busy !== 1'b0) begin errors++; $display("FAIL vbl_done: got done=%b busy=%b expected 1 0", h1.done, h1.busy); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (h1.in_ready !== 1'b0) begin errors++; $display("FAIL vbl_idle_ready: got %b expected 0", h1.in_ready); end
    end
    h1.in_valid = 1'b0;
    vblank1 = 1'b0;
    step();
    checks++; if (periods !== 8) begin errors++; $display("FAIL vbl_periods: got %0d expected 8", periods); end
    checks++; if (wr_cnt1 - base !== 768 || done_cnt1 - dn !== 1) begin errors++; $display("FAIL vbl_counts: got wr=%0d done=%0d expected 768 1", wr_cnt1 - base, done_cnt1 - dn); end
    checks++; if (h1.error !== 1'b0) begin errors++; $display("FAIL vbl_error: got %b expected 0", h1.error); end
    for (int i = 0; i < 768; i++) begin
      checks++; if (log_addr1[base + i] !== 10'(i) || log_data1[base + i] !== 8'(i)) begin errors++; $display("FAIL vbl_entry: got addr=%0d data=%0d expected %0d %0d", log_addr1[base + i], log_data1[base + i], i, i % 256); end
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    h0.start = 1'b1;
    step();
    h0.start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      h0.in_valid = 1'b1;
      h0.in_data = 8'(i);
      h0.start = (i == 10) ? 1'b1 : 1'b0;
      step();
    end
    h0.start = 1'b0;
    checks++; if (h0.error !== 1'b1 || h0.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got error=%b busy=%b expected 1 1", h0.error, h0.busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (h0.busy !== 1'b0 || h0.error !== 1'b0 || h0.done !== 1'b0 || h0.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_status: got busy=%b error=%b done=%b ready=%b expected 0 0 0 0", h0.busy, h0.error, h0.done, h0.in_ready); end
    checks++; if (bus0[19:0] !== 20'd0) begin errors++; $display("FAIL midrst_bus: got %h expected 00000", bus0[19:0]); end
    h0.in_valid = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    base = wr_cnt0;
    h0.start = 1'b1;
    step();
    h0.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      h0.in_valid = 1'b1;
      h0.in_data = 8'(i + 100);
      step();
    end
    h0.in_valid = 1'b0;
    repeat (2) step();
    checks++; if (wr_cnt0 - base !== 3) begin errors++; $display("FAIL midrst_count: got %0d expected 3", wr_cnt0 - base); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (log_addr0[base + i] !== 10'(i) || log_data0[base + i] !== 8'(i + 100)) begin errors++; $display("FAIL midrst_entry: got addr=%0d data=%0d expected %0d %0d", log_addr0[base + i], log_data0[base + i], i, i + 100); end
    end
    h0.abort = 1'b1;
    step();
    h0.abort = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    present0 = 1'b1;
    present1 = 1'b1;
    vblank0 = 1'b0;
    vblank1 = 1'b0;
    h0.enable = 1'b0; h0.start = 1'b0; h0.abort = 1'b0; h0.in_valid = 1'b0; h0.in_data = 8'd0;
    h1.enable = 1'b0; h1.start = 1'b0; h1.abort = 1'b0; h1.in_valid = 1'b0; h1.in_data = 8'd0;
    test_reset();
    test_full_load();
    test_no_present();
    test_abort();
    test_vblank();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
